// File: rtl/axi_burst_wr_pkg.sv
// Shared AXI constants and FSM encoding for the AXI4 write-burst engine.
package axi_burst_wr_pkg;

  localparam int          AXI_LEN_W_DEF = 8;
  localparam logic [1:0]  BURST_INCR    = 2'b01;
  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [3:0]  CACHE_DEF     = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // AxSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_burst_wr_if.sv
// Bundle of the command, native write-data and AXI4 write-channel signals.
interface axi_burst_wr_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = 8,
  parameter int AXI_ID_W  = 1
);

  logic                   run;
  logic [ADDR_W-1:0]      addr;
  logic [AXI_LEN_W-1:0]   length;
  logic                   ready;
  logic                   error;

  logic                   s_valid;
  logic [DATA_W-1:0]      s_wdata;
  logic [DATA_W/8-1:0]    s_wstrb;
  logic                   s_ready;

  logic [AXI_ID_W-1:0]    m_axi_awid;
  logic [ADDR_W-1:0]      m_axi_awaddr;
  logic [AXI_LEN_W-1:0]   m_axi_awlen;
  logic [2:0]             m_axi_awsize;
  logic [1:0]             m_axi_awburst;
  logic [1:0]             m_axi_awlock;
  logic [3:0]             m_axi_awcache;
  logic [2:0]             m_axi_awprot;
  logic [3:0]             m_axi_awqos;
  logic                   m_axi_awvalid;
  logic                   m_axi_awready;

  logic [DATA_W-1:0]      m_axi_wdata;
  logic [DATA_W/8-1:0]    m_axi_wstrb;
  logic                   m_axi_wlast;
  logic                   m_axi_wvalid;
  logic                   m_axi_wready;

  logic [AXI_ID_W-1:0]    m_axi_bid;
  logic [1:0]             m_axi_bresp;
  logic                   m_axi_bvalid;
  logic                   m_axi_bready;

  modport master (
    input  run, addr, length, s_valid, s_wdata, s_wstrb,
    input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output ready, error, s_ready,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
  );

  modport slave (
    output run, addr, length, s_valid, s_wdata, s_wstrb,
    output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  ready, error, s_ready,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
  );

endinterface

// File: rtl/axi_burst_wr_cnt.sv
// Beat counter for one burst; flags the beat whose index equals the latched length.
module axi_burst_wr_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi_burst_wr.sv
// AXI4 write-burst engine: one command in, length+1 W beats out, B response folded
// into a sticky error flag. One burst in flight at a time.
module axi_burst_wr
  import axi_burst_wr_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int AXI_LEN_W = AXI_LEN_W_DEF,
  parameter int AXI_ID_W  = 1
) (
  input  logic           clk,
  input  logic           rst,
  axi_burst_wr_if.master bus
);

  localparam logic [2:0] AW_SIZE = axi_size(DATA_W);

  state_t                 state_q;
  logic                   ready_q;
  logic                   error_q;
  logic                   awvalid_q;
  logic                   bready_q;
  logic [ADDR_W-1:0]      awaddr_q;
  logic [AXI_LEN_W-1:0]   awlen_q;

  logic in_data;
  logic w_xfer;
  logic cnt_clr;
  logic cnt_last;

  // W channel is a pure pass-through, gated so nothing leaks outside the data phase.
  assign in_data = (state_q == ST_DATA);
  assign w_xfer  = in_data & bus.s_valid & bus.m_axi_wready;
  assign cnt_clr = (state_q == ST_IDLE) & bus.run;

  axi_burst_wr_cnt #(
    .LEN_W (AXI_LEN_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (w_xfer),
    .len_i  (awlen_q),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      error_q   <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.run) begin
            awaddr_q  <= bus.addr;
            awlen_q   <= bus.length;
            error_q   <= 1'b0;
            ready_q   <= 1'b0;
            awvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.m_axi_awready) begin
            awvalid_q <= 1'b0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_xfer && cnt_last) begin
            bready_q <= 1'b1;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Any response other than OKAY (including EXOKAY) marks the burst as failed.
          if (bus.m_axi_bvalid) begin
            error_q  <= (bus.m_axi_bresp != RESP_OKAY);
            bready_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready         = ready_q;
  assign bus.error         = error_q;
  assign bus.s_ready       = in_data & bus.m_axi_wready;

  assign bus.m_axi_awid    = '0;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = AW_SIZE;
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awlock  = 2'b00;
  assign bus.m_axi_awcache = CACHE_DEF;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awqos   = 4'b0000;
  assign bus.m_axi_awvalid = awvalid_q;

  assign bus.m_axi_wdata   = bus.s_wdata;
  assign bus.m_axi_wstrb   = bus.s_wstrb;
  assign bus.m_axi_wlast   = in_data & cnt_last;
  assign bus.m_axi_wvalid  = in_data & bus.s_valid;
  assign bus.m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_burst_wr.sv
// Bench for axi_burst_wr: table of directed bursts, random bursts against a beat-count
// model, plus reset-state and mid-burst asynchronous reset sequences.
module tb_axi_burst_wr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_burst_wr_if bus ();

  axi_burst_wr dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    int          p_sv;
    int          p_wr;
    int          aw_dly;
    int          exp_beats;
    logic        exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic        prev_err;
  logic [31:0] dq [256];
  vec_t        vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic junk_ctrl();
    bus.run    = 1'($urandom_range(1, 0));
    bus.addr   = $urandom;
    bus.length = 8'($urandom);
  endtask

  task automatic burst(input vec_t v);
    int       k;
    int       cyc;
    int       bdly;
    logic     sv;
    logic     wr;
    logic [3:0] st;
    for (int i = 0; i <= int'(v.len); i++) dq[i] = $urandom;

    // Idle cycle: present the command, W inputs active but must be ignored.
    @(posedge clk); #1;
    bus.run = 1'b1; bus.addr = v.addr; bus.length = v.len;
    bus.s_valid = 1'b1; bus.m_axi_wready = 1'b1; bus.m_axi_awready = 1'b0;
    bus.m_axi_bvalid = 1'b0;
    @(negedge clk);
    chk("idle_ready", 64'(bus.ready), 64'(1'b1));
    chk("idle_error_held", 64'(bus.error), 64'(prev_err));
    chk("idle_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b0));
    chk("idle_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b0));

    for (int d = 0; d < v.aw_dly; d++) begin
      @(posedge clk); #1;
      junk_ctrl();
      bus.m_axi_awready = 1'b0;
      @(negedge clk);
      chk("aw_wait_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b1));
      chk("aw_wait_awaddr", 64'(bus.m_axi_awaddr), 64'(v.addr));
      chk("aw_wait_awlen", 64'(bus.m_axi_awlen), 64'(v.len));
      chk("aw_wait_sready", 64'(bus.s_ready), 64'(1'b0));
      chk("aw_wait_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b0));
      chk("aw_wait_ready", 64'(bus.ready), 64'(1'b0));
      chk("aw_wait_error", 64'(bus.error), 64'(1'b0));
    end

    @(posedge clk); #1;
    junk_ctrl();
    bus.m_axi_awready = 1'b1;
    @(negedge clk);
    chk("aw_hs_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b1));
    chk("aw_hs_awaddr", 64'(bus.m_axi_awaddr), 64'(v.addr));
    chk("aw_hs_awlen", 64'(bus.m_axi_awlen), 64'(v.len));
    chk("aw_hs_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b0));
    chk("aw_hs_error", 64'(bus.error), 64'(1'b0));

    // Data phase: k counts beats the model has seen accepted.
    k = 0;
    cyc = 0;
    while (k <= int'(v.len) && cyc < 4000) begin
      @(posedge clk); #1;
      junk_ctrl();
      bus.m_axi_awready = 1'b0;
      sv = ($urandom_range(99, 0) < v.p_sv);
      wr = ($urandom_range(99, 0) < v.p_wr);
      st = 4'($urandom);
      bus.s_valid = sv; bus.m_axi_wready = wr;
      bus.s_wdata = dq[k]; bus.s_wstrb = st;
      @(negedge clk);
      chk("dat_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b0));
      chk("dat_wvalid", 64'(bus.m_axi_wvalid), 64'(sv));
      chk("dat_sready", 64'(bus.s_ready), 64'(wr));
      chk("dat_wdata", 64'(bus.m_axi_wdata), 64'(dq[k]));
      chk("dat_wstrb", 64'(bus.m_axi_wstrb), 64'(st));
      chk("dat_wlast", 64'(bus.m_axi_wlast), 64'(k == int'(v.len)));
      chk("dat_awaddr", 64'(bus.m_axi_awaddr), 64'(v.addr));
      chk("dat_bready", 64'(bus.m_axi_bready), 64'(1'b0));
      if (sv && wr) k++;
      cyc++;
    end
    if (cyc >= 4000) chk("dat_timeout", 64'(cyc), 64'(0));

    bdly = $urandom_range(2, 0);
    for (int d = 0; d < bdly; d++) begin
      @(posedge clk); #1;
      junk_ctrl();
      bus.s_valid = 1'b1; bus.m_axi_wready = 1'b1; bus.m_axi_bvalid = 1'b0;
      @(negedge clk);
      chk("resp_wait_bready", 64'(bus.m_axi_bready), 64'(1'b1));
      chk("resp_wait_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b0));
      chk("resp_wait_sready", 64'(bus.s_ready), 64'(1'b0));
      chk("resp_wait_ready", 64'(bus.ready), 64'(1'b0));
    end

    @(posedge clk); #1;
    junk_ctrl();
    bus.s_valid = 1'b1; bus.m_axi_wready = 1'b1;
    bus.m_axi_bvalid = 1'b1; bus.m_axi_bresp = v.resp; bus.m_axi_bid = 1'b0;
    @(negedge clk);
    chk("resp_bready", 64'(bus.m_axi_bready), 64'(1'b1));
    chk("resp_ready", 64'(bus.ready), 64'(1'b0));

    @(posedge clk); #1;
    bus.run = 1'b0; bus.s_valid = 1'b0; bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    @(negedge clk);
    chk("done_ready", 64'(bus.ready), 64'(1'b1));
    chk("done_error", 64'(bus.error), 64'(v.exp_err));
    chk("done_bready", 64'(bus.m_axi_bready), 64'(1'b0));
    chk("done_beats", 64'(k), 64'(v.exp_beats));
    prev_err = v.exp_err;
    $display("burst addr=%08h len=%0d beats=%0d resp=%0d error=%0d",
             v.addr, v.len, k, v.resp, bus.error);
  endtask

  initial begin
    vec_t rv;
    rst_n = 1'b0;
    bus.run = 1'b0; bus.addr = '0; bus.length = '0;
    bus.s_valid = 1'b1; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b1;
    bus.m_axi_bid = '0; bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;
    prev_err = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.ready), 64'(1'b1));
    chk("rst_error", 64'(bus.error), 64'(1'b0));
    chk("rst_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b0));
    chk("rst_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b0));
    chk("rst_sready", 64'(bus.s_ready), 64'(1'b0));
    chk("rst_bready", 64'(bus.m_axi_bready), 64'(1'b0));
    chk("rst_awaddr", 64'(bus.m_axi_awaddr), 64'(0));
    chk("rst_awlen", 64'(bus.m_axi_awlen), 64'(0));
    chk("rst_wlast", 64'(bus.m_axi_wlast), 64'(1'b0));
    chk("const_awsize", 64'(bus.m_axi_awsize), 64'(3'd2));
    chk("const_awburst", 64'(bus.m_axi_awburst), 64'(2'b01));
    chk("const_awcache", 64'(bus.m_axi_awcache), 64'(4'b0011));
    chk("const_awid", 64'(bus.m_axi_awid), 64'(0));
    chk("const_awlock", 64'(bus.m_axi_awlock), 64'(0));
    chk("const_awprot", 64'(bus.m_axi_awprot), 64'(0));
    chk("const_awqos", 64'(bus.m_axi_awqos), 64'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.s_valid = 1'b0;

    vecs[0] = '{32'h0000_1000, 8'd3,   2'b00, 100, 100, 0,  4,   1'b0};
    vecs[1] = '{32'h0000_0040, 8'd0,   2'b00, 100, 100, 0,  1,   1'b0};
    vecs[2] = '{32'h0000_2000, 8'd7,   2'b00, 50,  50,  0,  8,   1'b0};
    vecs[3] = '{32'h0000_3000, 8'd2,   2'b00, 100, 100, 10, 3,   1'b0};
    vecs[4] = '{32'h0000_4000, 8'd1,   2'b10, 100, 100, 1,  2,   1'b1};
    vecs[5] = '{32'h0000_5000, 8'd0,   2'b00, 100, 70,  0,  1,   1'b0};
    vecs[6] = '{32'h0000_6000, 8'd255, 2'b11, 90,  90,  2,  256, 1'b1};
    vecs[7] = '{32'h0000_7004, 8'd4,   2'b01, 60,  80,  3,  5,   1'b1};
    for (int i = 0; i < 8; i++) burst(vecs[i]);

    for (int i = 0; i < 10; i++) begin
      rv.addr      = $urandom & 32'hFFFF_FFFC;
      rv.len       = 8'($urandom_range(15, 0));
      rv.resp      = 2'($urandom);
      rv.p_sv      = $urandom_range(100, 30);
      rv.p_wr      = $urandom_range(100, 30);
      rv.aw_dly    = $urandom_range(3, 0);
      rv.exp_beats = int'(rv.len) + 1;
      rv.exp_err   = (rv.resp != 2'b00);
      burst(rv);
    end

    // Asynchronous reset while the second beat of a 16-beat burst is on the bus.
    @(posedge clk); #1;
    bus.run = 1'b1; bus.addr = 32'h0000_8000; bus.length = 8'd15;
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1;
    bus.s_valid = 1'b1; bus.s_wdata = 32'hA5A5_0001; bus.s_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.run = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    bus.s_wdata = 32'hA5A5_0002;
    @(negedge clk);
    chk("midrst_pre_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b1));
    chk("midrst_pre_wlast", 64'(bus.m_axi_wlast), 64'(1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.ready), 64'(1'b1));
    chk("midrst_wvalid", 64'(bus.m_axi_wvalid), 64'(1'b0));
    chk("midrst_sready", 64'(bus.s_ready), 64'(1'b0));
    chk("midrst_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b0));
    chk("midrst_bready", 64'(bus.m_axi_bready), 64'(1'b0));
    chk("midrst_error", 64'(bus.error), 64'(1'b0));
    chk("midrst_awaddr", 64'(bus.m_axi_awaddr), 64'(0));
    chk("midrst_awlen", 64'(bus.m_axi_awlen), 64'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.s_valid = 1'b0; bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    @(negedge clk);
    chk("postrst_ready", 64'(bus.ready), 64'(1'b1));
    chk("postrst_awvalid", 64'(bus.m_axi_awvalid), 64'(1'b0));
    prev_err = 1'b0;
    rv = '{32'h0000_9000, 8'd5, 2'b00, 80, 80, 1, 6, 1'b0};
    burst(rv);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_wr.md
Name: axi_burst_wr

Overview:
AXI4 write-burst engine sitting directly downstream of the iob2axi FIFO/burst-splitting logic. It accepts one burst command (start address and AXI length) on a run/ready control interface. It then streams exactly length+1 beats from a native valid/ready data port onto the AXI4 W channel, and reports the B-channel response. One burst is in flight at a time. 4 KB boundary splitting is the upstream block's job.

Parameters:
ADDR_W, 32, byte address width of the command and m_axi_awaddr
DATA_W, 32, data width of the native port and the AXI W channel; a power of two, 8 to 1024
AXI_LEN_W, 8, width of length and m_axi_awlen
AXI_ID_W, 1, width of the AXI ID fields

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
run  in  1  start pulse; sampled only while ready=1
addr  in  ADDR_W  burst start byte address, DATA_W/8-aligned
length  in  AXI_LEN_W  beats minus one
ready  out  1  engine idle and able to accept run
error  out  1  sticky: last burst got a non-OKAY response
s_valid  in  1  native write-data valid
s_wdata  in  DATA_W  native write data
s_wstrb  in  DATA_W/8  native byte strobes
s_ready  out  1  native beat accepted this cycle
m_axi_awid  out  AXI_ID_W  constant 0
m_axi_awaddr  out  ADDR_W  latched addr
m_axi_awlen  out  AXI_LEN_W  latched length
m_axi_awsize  out  3  constant log2(DATA_W/8)
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awlock  out  2  constant 0
m_axi_awcache  out  4  constant 4'b0011
m_axi_awprot  out  3  constant 0
m_axi_awqos  out  4  constant 0
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_W  = s_wdata
m_axi_wstrb  out  DATA_W/8  = s_wstrb
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  data valid
m_axi_wready  in  1  data ready
m_axi_bid  in  AXI_ID_W  ignored
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset (rst=0, async): state=IDLE, ready=1, error=0, awvalid=0, wvalid=0, bready=0, s_ready=0, beat counter=0, awaddr=0, awlen=0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: ready=1. On run=1, latch addr and length, clear error and counter, and go to ADDR on the next edge. ready drops the cycle after run.
- ADDR: registered awvalid=1, held with awaddr/awlen stable until awready=1. Handshake moves to DATA. No W beat is issued before the AW handshake completes.
- DATA: combinational pass-through, wvalid=s_valid and s_ready=wready. A beat transfers when s_valid & wready; the counter increments on each transfer.
- wlast = (counter==latched length) in DATA. A transfer with wlast=1 moves to RESP.
- length=0 gives a single beat with wlast=1 on it. length=2^AXI_LEN_W-1 gives a full-length burst; the counter is AXI_LEN_W bits and never wraps within a burst.
- RESP: bready=1. On bvalid, error <= (bresp!=2'b00) and go to IDLE. error holds until the next accepted run.
- Outside DATA: s_ready=0 and wvalid=0. s_valid is ignored.
- run while ready=0 is ignored; no queuing.
- Reset asserted mid-burst aborts immediately to IDLE. AXI protocol completion is not guaranteed; the system resets the slave together with this block.
- Latency: run to awvalid is 1 cycle. AW handshake to first possible W beat is 1 cycle. bvalid to ready=1 is 1 cycle.
- Back-to-back: minimum IDLE dwell is 1 cycle between bursts.

Decomposition:
- Shared package/header holds the AXI constants: AXI_LEN_W default, BURST_INCR=2'b01, RESP_OKAY=2'b00, CACHE default, and the FSM state encodings.
- AW/W/B port bundles come from the existing axi.vh port macros (write-only variant).
- One natural sub-module, axi_burst_wr_cnt: the beat counter plus wlast compare.

Test Plan:
- addr=0x1000, length=3, awready=1, wready=1, s_valid=1 -> awaddr=0x1000, awlen=3, 4 beats, wlast on beat 4 only, bresp=0 -> error=0, ready=1 one cycle after bvalid.
- length=0 -> exactly one beat carrying wlast=1; FSM returns to IDLE after B.
- length=7, s_valid and wready toggled randomly -> exactly 8 transfers, data order preserved, no transfer counted unless both are high.
- awready held 0 for 10 cycles -> awvalid and awaddr stay stable, s_ready=0 throughout, no W activity.
- bresp=2'b10 -> error=1 and held; next run clears it; run while busy is ignored.
- rst=0 asserted during the DATA beat 2 of length=15 -> all valids 0, ready=1 immediately; a new burst then completes normally.
